fir_decim_buffer: RTL and testbench
===================================

Name: fir_decim_buffer

Overview:
- Downstream stage of the 2-tap FIR (`filterfir`); consumes its 10-bit `dataout` stream.
- Block-averages every DECIM accepted samples into one 10-bit decimated sample.
- Buffers the decimated samples in a small show-ahead FIFO.
- Presents them to the next consumer over a valid/ready handshake, so the bursty consumer decouples from the continuous filter rate.

Parameters:
- IN_W, 10, sample width (matches FIR output width).
- DECIM, 4, decimation factor; power of 2, legal range 2..16.
- DEPTH, 8, FIFO entries; power of 2, legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_data holds a sample this cycle.
- in_data  input  IN_W  unsigned FIR output sample.
- out_valid  output  1  FIFO non-empty; out_data holds the head entry.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_data  output  IN_W  head entry; 0 when out_valid=0.
- out_count  output  log2(DEPTH)+1  number of FIFO entries held.
- overflow  output  1  sticky: a decimated result was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clock edge) clears everything:
  - acc=0, phase=0, rd_ptr=0, wr_ptr=0, out_count=0.
  - out_valid=0, out_data=0, overflow=0.
  - Reset mid-operation discards the partial accumulation and all FIFO contents. rst has priority over all other inputs.
- Accumulator:
  - acc is IN_W+log2(DECIM) bits; it never overflows.
  - phase counts 0..DECIM-1.
  - in_valid=0: acc and phase hold. Gaps are allowed anywhere inside a group.
  - in_valid=1 and phase<DECIM-1: acc += in_data; phase += 1.
  - in_valid=1 and phase=DECIM-1: result = (acc+in_data) >> log2(DECIM), truncating (no rounding), exactly IN_W bits. Push is requested this cycle; acc=0, phase=0.
- Latency: the result of a group's final sample (accepted at edge t) is visible at the FIFO head, with out_valid=1, after edge t when the FIFO was previously empty. It is never combinationally visible in the same cycle.
- FIFO:
  - Show-ahead: out_data = mem[rd_ptr] whenever out_count>0, else 0.
  - Pop occurs when out_valid && out_ready. out_ready is ignored when empty.
  - Pointers wrap modulo DEPTH.
  - out_count += push_accepted - pop.
  - Order is strictly first-in first-out.
- Full and simultaneous events:
  - Push and pop in the same cycle (any count including full): both occur, out_count unchanged, no overflow.
  - Push when out_count=DEPTH with no pop: the result is dropped, FIFO unchanged, overflow←1. The accumulator still restarts (phase=0, acc=0).
  - overflow stays 1 until rst.
- Push into an empty FIFO with no pop: out_count=1 and out_valid=1 after the edge.
- Outputs out_valid, out_count and overflow derive from registered state only (no combinational path from in_* or out_ready).

Test Plan:
- DECIM=4, continuous in_valid, samples 100,200,300,400 → out_valid rises the cycle after 400 is accepted; out_data=250, out_count=1. Pop with out_ready=1 → out_count=0, out_data=0.
- Samples 1023×4 → out_data=1023 (no wrap). Samples 1,1,1,2 → out_data=1 (truncation of 5/4).
- Samples 10,20,30,40 with in_valid low for 3 cycles between each → single result 25. No output before the 4th sample.
- out_ready=0, 9 full groups of constant value k (groups k=1..9) → out_count=8, overflow=1, group 9 lost. Then out_ready=1 → drains 1..8 in order, out_count reaches 0, overflow remains 1.
- FIFO full, final sample of a group accepted in the same cycle as a pop → out_count stays 8, overflow stays 0, new result appears at the tail.
- rst asserted after 2 samples of a group with 3 entries queued → next cycle out_valid=0, out_count=0, overflow=0. The following 4 samples 4,8,12,16 → out_data=10 (no residue from before reset).

Source files
------------

// File: rtl/fir_decim_buffer.sv
// rtl/fir_decim_buffer.sv - block-average decimator feeding a show-ahead valid/ready FIFO
// Averages every DECIM accepted samples and queues the results for a bursty consumer.
module fir_decim_buffer #(
  parameter int IN_W  = 10,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IN_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     overflow
);

  localparam int DW = $clog2(DECIM);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = IN_W + DW;

  logic [SW-1:0]   acc_q, acc_d, sum;
  logic [DW-1:0]   phase_q, phase_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [IN_W-1:0] mem_q [DEPTH];
  logic [IN_W-1:0] result;
  logic            last, push_req, push_ok, pop;

  always_comb begin
    sum      = acc_q + SW'(in_data);
    result   = IN_W'(sum >> DW);
    last     = (phase_q == DW'(DECIM - 1));
    push_req = in_valid && last;
    pop      = (count_q != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok  = push_req && ((count_q != CW'(DEPTH)) || pop);

    acc_d   = acc_q;
    phase_d = phase_q;
    if (in_valid) begin
      if (last) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + DW'(1);
      end
    end

    rd_ptr_d   = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    overflow_d = overflow_q | (push_req & ~push_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      phase_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q covers them.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_count = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// tb/tb_fir_decim_buffer.sv - self-checking bench for fir_decim_buffer
// Queue-based reference model checked every cycle, plus literal expectations.
module tb_fir_decim_buffer;

  localparam int DECIM = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] out_data;
  logic [3:0] out_count;
  logic       overflow;

  fir_decim_buffer #(.IN_W(10), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_acc = 0;
  int m_phase = 0;
  int m_q[$];
  bit m_ovf = 0;
  bit started = 0;

  always @(posedge clk) begin
    int res;
    bit push;
    if (rst) begin
      m_acc = 0; m_phase = 0; m_q = {}; m_ovf = 0; started = 1;
    end else begin
      push = 0;
      res = 0;
      if (in_valid) begin
        if (m_phase == DECIM - 1) begin
          res = (m_acc + int'(in_data)) / DECIM;
          push = 1; m_acc = 0; m_phase = 0;
        end else begin
          m_acc += int'(in_data); m_phase++;
        end
      end
      if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(res);
        else m_ovf = 1;
      end
    end
  end

  bit    lit_en = 0;
  string lit_name;
  int    lit_valid, lit_data, lit_count, lit_ovf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_valid", int'(out_valid), (m_q.size() > 0) ? 1 : 0);
      chk("model_data", int'(out_data), (m_q.size() > 0) ? m_q[0] : 0);
      chk("model_count", int'(out_count), m_q.size());
      chk("model_ovf", int'(overflow), int'(m_ovf));
      if (lit_en) begin
        chk({lit_name, "_valid"}, int'(out_valid), lit_valid);
        chk({lit_name, "_data"}, int'(out_data), lit_data);
        chk({lit_name, "_count"}, int'(out_count), lit_count);
        chk({lit_name, "_ovf"}, int'(overflow), lit_ovf);
      end
    end
  end

  task automatic step(input bit v, input int d, input bit rdy);
    in_valid = v;
    in_data = 10'(d);
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input int v, input int d, input int c, input int o);
    lit_name = name; lit_valid = v; lit_data = d; lit_count = c; lit_ovf = o;
    in_valid = 1'b0;
    out_ready = 1'b0;
    lit_en = 1'b1;
    @(negedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic group(input int a, input int b, input int c, input int d, input bit rdy);
    step(1, a, rdy); step(1, b, rdy); step(1, c, rdy); step(1, d, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
    expect_lit("reset", 0, 0, 0, 0);

    step(1, 100, 0); step(1, 200, 0); step(1, 300, 0);
    expect_lit("partial", 0, 0, 0, 0);
    step(1, 400, 0);
    expect_lit("avg250", 1, 250, 1, 0);
    step(0, 0, 1);
    expect_lit("pop250", 0, 0, 0, 0);

    group(1023, 1023, 1023, 1023, 0);
    expect_lit("max1023", 1, 1023, 1, 0);
    step(0, 0, 1);
    group(1, 1, 1, 2, 0);
    expect_lit("trunc", 1, 1, 1, 0);
    step(0, 0, 1);

    for (int i = 1; i <= 4; i++) begin
      step(1, 10 * i, 0);
      if (i < 4) begin
        for (int g = 0; g < 3; g++) step(0, 0, 0);
        expect_lit("gap_none", 0, 0, 0, 0);
      end
    end
    expect_lit("gap25", 1, 25, 1, 0);
    step(0, 0, 1);

    for (int k = 1; k <= 9; k++) group(k, k, k, k, 0);
    expect_lit("full", 1, 1, 8, 1);
    for (int k = 1; k <= 8; k++) begin
      expect_lit("drain", 1, k, 9 - k, 1);
      step(0, 0, 1);
    end
    expect_lit("drained", 0, 0, 0, 1);

    do_reset();
    expect_lit("ovf_clear", 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) group(k, k, k, k, 0);
    step(1, 20, 0); step(1, 20, 0); step(1, 20, 0); step(1, 20, 1);
    expect_lit("simul", 1, 2, 8, 0);
    for (int k = 2; k <= 8; k++) step(0, 0, 1);
    expect_lit("tail20", 1, 20, 1, 0);
    step(0, 0, 1);

    group(5, 5, 5, 5, 0); group(6, 6, 6, 6, 0); group(7, 7, 7, 7, 0);
    step(1, 50, 0); step(1, 60, 0);
    expect_lit("pre_rst", 1, 5, 3, 0);
    do_reset();
    expect_lit("post_rst", 0, 0, 0, 0);
    group(4, 8, 12, 16, 0);
    expect_lit("no_residue", 1, 10, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
